writeback_arbiter: RTL and testbench

//  Write-side driver for the register file and the scoreboard's register-result-status table.

---
 rtl/writeback_arbiter_pkg.sv | 8 +
 rtl/writeback_arbiter_if.sv | 24 ++
 rtl/writeback_arbiter_rr_arbiter.sv | 40 ++++
 rtl/writeback_arbiter.sv | 95 +++++++++
 tb/tb_writeback_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared constants for the writeback arbiter: register file geometry and counter width.
package writeback_arbiter_pkg;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 2 ** REG_AW;
    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned WB_CNT_W = 16;
endpackage

// File: rtl/writeback_arbiter_if.sv
// Functional-unit result bus and registered register-file write port.
interface writeback_arbiter_if #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned DATA_W = writeback_arbiter_pkg::DATA_W,
    parameter int unsigned REG_AW = writeback_arbiter_pkg::REG_AW
);
    logic [NUM_FU-1:0]        fu_valid;
    logic [NUM_FU*REG_AW-1:0] fu_dest;
    logic [NUM_FU*DATA_W-1:0] fu_data;
    logic [NUM_FU-1:0]        fu_ready;
    logic                     wb_enable;
    logic [REG_AW-1:0]        wb_dest;
    logic [DATA_W-1:0]        wb_data;

    modport master (
        output fu_valid, fu_dest, fu_data,
        input  fu_ready, wb_enable, wb_dest, wb_data
    );

    modport slave (
        input  fu_valid, fu_dest, fu_data,
        output fu_ready, wb_enable, wb_dest, wb_data
    );
endinterface

// File: rtl/writeback_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1 upward with wrap, pointer moves to the accepted index.
module writeback_arbiter_rr_arbiter #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned IDX_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_FU-1:0] req_i,
    input  logic              accept_i,
    output logic [NUM_FU-1:0] gnt_o,
    output logic [IDX_W-1:0]  gnt_idx_o
);
    logic [IDX_W-1:0] ptr_q;
    logic             found;
    int unsigned      idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned off = 1; off <= NUM_FU; off++) begin
            idx = (32'(ptr_q) + off) % NUM_FU;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = IDX_W'(idx);
            end
        end
    end

    // Reset pointer to the last index so FU0 wins the first search.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= IDX_W'(NUM_FU - 1);
        end else if (accept_i) begin
            ptr_q <= gnt_idx_o;
        end
    end
endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: round-robin result collection, registered RF write port, busy table, commit counter.
module writeback_arbiter #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned DATA_W = writeback_arbiter_pkg::DATA_W,
    parameter int unsigned REG_AW = writeback_arbiter_pkg::REG_AW
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      issue_valid,
    input  logic [REG_AW-1:0]                         issue_dest,
    input  logic [REG_AW-1:0]                         query_rs,
    input  logic [REG_AW-1:0]                         query_rt,
    output logic                                      busy_rs,
    output logic                                      busy_rt,
    output logic                                      busy_dest,
    writeback_arbiter_if.slave                        bus,
    output logic [(2**REG_AW)-1:0]                    busy_vec,
    output logic [writeback_arbiter_pkg::WB_CNT_W-1:0] wb_count
);
    import writeback_arbiter_pkg::*;

    localparam int unsigned IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]     gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  accept;
    logic [REG_AW-1:0]     dest_a [NUM_FU];
    logic [DATA_W-1:0]     data_a [NUM_FU];
    logic [REG_AW-1:0]     sel_dest;
    logic [DATA_W-1:0]     sel_data;

    logic                  wb_enable_q, wb_enable_d;
    logic [REG_AW-1:0]     wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;
    logic [(2**REG_AW)-1:0] busy_q, busy_d;
    logic [WB_CNT_W-1:0]   wb_cnt_q, wb_cnt_d;

    writeback_arbiter_rr_arbiter #(.NUM_FU(NUM_FU), .IDX_W(IDX_W)) u_rr (
        .clk_i     (clock),
        .rst_ni    (reset),
        .req_i     (bus.fu_valid),
        .accept_i  (accept),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            dest_a[i] = bus.fu_dest[i*REG_AW +: REG_AW];
            data_a[i] = bus.fu_data[i*DATA_W +: DATA_W];
        end
    end

    assign bus.fu_ready = gnt & {NUM_FU{reset}};
    assign accept       = reset & (|gnt);
    assign sel_dest     = dest_a[gnt_idx];
    assign sel_data     = data_a[gnt_idx];

    always_comb begin
        wb_enable_d = accept && (sel_dest != REG_AW'(REG_ZERO));
        wb_dest_d   = accept ? sel_dest : wb_dest_q;
        wb_data_d   = accept ? sel_data : wb_data_q;
        wb_cnt_d    = wb_enable_q ? wb_cnt_q + WB_CNT_W'(1) : wb_cnt_q;
        // Clear before set so a re-issue in the commit cycle keeps the register busy.
        busy_d = busy_q;
        if (wb_enable_q) busy_d[wb_dest_q] = 1'b0;
        if (issue_valid) busy_d[issue_dest] = 1'b1;
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wb_enable_q <= 1'b0;
            wb_dest_q   <= '0;
            wb_data_q   <= '0;
            busy_q      <= '0;
            wb_cnt_q    <= '0;
        end else begin
            wb_enable_q <= wb_enable_d;
            wb_dest_q   <= wb_dest_d;
            wb_data_q   <= wb_data_d;
            busy_q      <= busy_d;
            wb_cnt_q    <= wb_cnt_d;
        end
    end

    assign bus.wb_enable = wb_enable_q;
    assign bus.wb_dest   = wb_dest_q;
    assign bus.wb_data   = wb_data_q;
    assign busy_vec      = busy_q;
    assign wb_count      = wb_cnt_q;
    assign busy_rs       = busy_q[query_rs];
    assign busy_rt       = busy_q[query_rt];
    assign busy_dest     = busy_q[issue_dest];
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: vector table, directed corner sequences, random run against a reference model.
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    localparam int NFU = 4;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NR  = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_dest = '0;
    logic [AW-1:0] query_rs = '0;
    logic [AW-1:0] query_rt = '0;
    logic          busy_rs, busy_rt, busy_dest;
    logic [NR-1:0] busy_vec;
    logic [15:0]   wb_count;

    writeback_arbiter_if #(.NUM_FU(NFU), .DATA_W(DW), .REG_AW(AW)) bus ();

    writeback_arbiter #(.NUM_FU(NFU), .DATA_W(DW), .REG_AW(AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .query_rs    (query_rs),
        .query_rt    (query_rt),
        .busy_rs     (busy_rs),
        .busy_rt     (busy_rt),
        .busy_dest   (busy_dest),
        .bus         (bus),
        .busy_vec    (busy_vec),
        .wb_count    (wb_count)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_fu(input int i, input logic v, input logic [AW-1:0] d, input logic [DW-1:0] x);
        bus.fu_valid[i]          = v;
        bus.fu_dest[i*AW +: AW]  = d;
        bus.fu_data[i*DW +: DW]  = x;
    endtask

    task automatic do_reset;
        reset          = 1'b0;
        bus.fu_valid   = '0;
        issue_valid    = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    function automatic int pick(input logic [NFU-1:0] v, input int last);
        for (int k = 1; k <= NFU; k++)
            if (v[(last + k) % NFU]) return (last + k) % NFU;
        return -1;
    endfunction

    typedef struct {
        logic [NFU-1:0] valid;
        logic [NFU-1:0] exp_ready;
        logic           exp_en;
        logic [AW-1:0]  exp_dest;
        logic [DW-1:0]  exp_data;
        logic [15:0]    exp_count;
    } vec_t;

    vec_t vt [10];

    // Reference model state for the random phase
    int             m_last;
    logic [NR-1:0]  m_busy;
    logic           m_wb_en;
    logic [AW-1:0]  m_wb_dest;
    logic [DW-1:0]  m_wb_data;
    logic [15:0]    m_count;
    logic [NFU-1:0] rv;
    logic [AW-1:0]  rd [NFU];
    logic [DW-1:0]  rx [NFU];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        logic [NFU-1:0] exp_ready;

        bus.fu_valid = '0;
        bus.fu_dest  = '0;
        bus.fu_data  = '0;

        // FU dests 1,2,0,4; FU i data 0x100+i. Records run back to back from reset.
        vt[0] = '{4'b1111, 4'b0001, 1'b1, 5'd1, 32'h100, 16'd0};
        vt[1] = '{4'b1111, 4'b0010, 1'b1, 5'd2, 32'h101, 16'd1};
        vt[2] = '{4'b1111, 4'b0100, 1'b0, 5'd0, 32'h102, 16'd2};
        vt[3] = '{4'b1111, 4'b1000, 1'b1, 5'd4, 32'h103, 16'd2};
        vt[4] = '{4'b1111, 4'b0001, 1'b1, 5'd1, 32'h100, 16'd3};
        vt[5] = '{4'b0000, 4'b0000, 1'b0, 5'd0, 32'h0,   16'd4};
        vt[6] = '{4'b0100, 4'b0100, 1'b0, 5'd0, 32'h102, 16'd4};
        vt[7] = '{4'b1001, 4'b1000, 1'b1, 5'd4, 32'h103, 16'd4};
        vt[8] = '{4'b0011, 4'b0001, 1'b1, 5'd1, 32'h100, 16'd5};
        vt[9] = '{4'b0110, 4'b0010, 1'b1, 5'd2, 32'h101, 16'd6};

        // Reset held with every FU requesting
        reset = 1'b0;
        set_fu(0, 1'b1, 5'd1, 32'h100);
        set_fu(1, 1'b1, 5'd2, 32'h101);
        set_fu(2, 1'b1, 5'd0, 32'h102);
        set_fu(3, 1'b1, 5'd4, 32'h103);
        #1;
        chk("rst_ready0", bus.fu_ready, 4'b0000);
        tick();
        chk("rst_ready1", bus.fu_ready, 4'b0000);
        tick();
        chk("rst_ready2", bus.fu_ready, 4'b0000);
        chk("rst_wb_en", bus.wb_enable, 1'b0);
        chk("rst_busy", busy_vec, '0);
        chk("rst_count", wb_count, 16'd0);

        reset = 1'b1;
        for (int r = 0; r < 10; r++) begin
            bus.fu_valid = vt[r].valid;
            #1;
            chk($sformatf("tbl%0d_ready", r), bus.fu_ready, vt[r].exp_ready);
            tick();
            chk($sformatf("tbl%0d_en", r), bus.wb_enable, vt[r].exp_en);
            if (vt[r].exp_en) begin
                chk($sformatf("tbl%0d_dest", r), bus.wb_dest, vt[r].exp_dest);
                chk($sformatf("tbl%0d_data", r), bus.wb_data, vt[r].exp_data);
            end
            chk($sformatf("tbl%0d_count", r), wb_count, vt[r].exp_count);
            chk($sformatf("tbl%0d_busy0", r), busy_vec[0], 1'b0);
        end

        // Single result: issue r5, FU1 writes it back, busy clears at the commit edge
        do_reset();
        issue_valid = 1'b1;
        issue_dest  = 5'd5;
        tick();
        issue_valid = 1'b0;
        chk("r5_busy_set", busy_vec[5], 1'b1);
        set_fu(1, 1'b1, 5'd5, 32'hDEADBEEF);
        query_rs = 5'd5;
        #1;
        chk("r5_ready", bus.fu_ready, 4'b0010);
        chk("r5_busy_rs", busy_rs, 1'b1);
        tick();
        set_fu(1, 1'b0, 5'd0, 32'h0);
        chk("r5_wb_en", bus.wb_enable, 1'b1);
        chk("r5_wb_dest", bus.wb_dest, 5'd5);
        chk("r5_wb_data", bus.wb_data, 32'hDEADBEEF);
        chk("r5_busy_hold", busy_vec[5], 1'b1);
        tick();
        chk("r5_busy_clr", busy_vec[5], 1'b0);
        chk("r5_count", wb_count, 16'd1);
        chk("r5_wb_idle", bus.wb_enable, 1'b0);

        // Commit of r7 coincides with a new issue to r7: set wins
        do_reset();
        issue_valid = 1'b1;
        issue_dest  = 5'd7;
        tick();
        issue_valid = 1'b0;
        set_fu(0, 1'b1, 5'd7, 32'h77);
        tick();
        set_fu(0, 1'b0, 5'd0, 32'h0);
        chk("r7_wb_en", bus.wb_enable, 1'b1);
        chk("r7_wb_dest", bus.wb_dest, 5'd7);
        issue_valid = 1'b1;
        issue_dest  = 5'd7;
        query_rs    = 5'd7;
        tick();
        issue_valid = 1'b0;
        chk("r7_busy_kept", busy_vec[7], 1'b1);
        chk("r7_busy_rs", busy_rs, 1'b1);
        chk("r7_busy_dest", busy_dest, 1'b1);
        chk("r7_count", wb_count, 16'd1);

        // Reset while r9 write is in flight
        do_reset();
        issue_valid = 1'b1;
        issue_dest  = 5'd9;
        tick();
        issue_valid = 1'b0;
        set_fu(0, 1'b1, 5'd9, 32'h99);
        tick();
        set_fu(0, 1'b0, 5'd0, 32'h0);
        chk("r9_wb_en", bus.wb_enable, 1'b1);
        chk("r9_busy", busy_vec[9], 1'b1);
        reset = 1'b0;
        set_fu(1, 1'b1, 5'd3, 32'h33);
        #1;
        chk("r9_rst_ready", bus.fu_ready, 4'b0000);
        tick();
        chk("r9_rst_wb_en", bus.wb_enable, 1'b0);
        chk("r9_rst_busy", busy_vec, '0);
        chk("r9_rst_count", wb_count, 16'd0);
        reset = 1'b1;
        bus.fu_valid = 4'b1111;
        #1;
        chk("r9_ptr_fu0", bus.fu_ready, 4'b0001);

        // Random run against the reference model
        do_reset();
        m_last = NFU - 1; m_busy = '0; m_wb_en = 1'b0;
        m_wb_dest = '0; m_wb_data = '0; m_count = '0; rv = '0;
        for (int i = 0; i < NFU; i++) begin rd[i] = '0; rx[i] = '0; end
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NFU; i++) begin
                if (!rv[i] && $urandom_range(2) == 0) begin
                    rv[i] = 1'b1;
                    rd[i] = AW'($urandom_range(NR - 1));
                    rx[i] = $urandom;
                end
                set_fu(i, rv[i], rd[i], rx[i]);
            end
            issue_dest  = AW'($urandom_range(NR - 1));
            issue_valid = ($urandom_range(3) == 0) && !m_busy[issue_dest];
            query_rs    = AW'($urandom_range(NR - 1));
            query_rt    = AW'($urandom_range(NR - 1));
            #1;
            g = pick(rv, m_last);
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("rnd_ready", bus.fu_ready, exp_ready);
            chk("rnd_busy_rs", busy_rs, m_busy[query_rs]);
            chk("rnd_busy_rt", busy_rt, m_busy[query_rt]);
            chk("rnd_busy_dest", busy_dest, m_busy[issue_dest]);
            tick();
            if (m_wb_en) begin
                m_busy[m_wb_dest] = 1'b0;
                m_count = m_count + 16'd1;
            end
            if (issue_valid && issue_dest != 0) m_busy[issue_dest] = 1'b1;
            m_wb_en = (g >= 0) && (rd[g] != 0);
            if (g >= 0) begin
                m_wb_dest = rd[g];
                m_wb_data = rx[g];
                m_last    = g;
                rv[g]     = 1'b0;
            end
            chk("rnd_wb_en", bus.wb_enable, m_wb_en);
            if (m_wb_en) begin
                chk("rnd_wb_dest", bus.wb_dest, m_wb_dest);
                chk("rnd_wb_data", bus.wb_data, m_wb_data);
            end
            chk("rnd_busy_vec", busy_vec, m_busy);
            chk("rnd_count", wb_count, m_count);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
